fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Pipeline controller for the 5-stage core: tracks destination registers of in-flight instructions (EX, MEM, WB slots) and drives the select codes of the two EX-stage ALU operand forwarding muxes.
- Detects load-use hazards, inserts one bubble and stalls PC and IF/ID. Honours a data-memory freeze and a branch squash.
- Sits between ID-stage decode and the ID/EX, EX/MEM and MEM/WB pipeline registers. Keeps two saturating event counters for performance debug.

Parameters:
- REG_AW, 5, register address width
- CNT_W, 32, width of each performance counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- id_valid_i  in  1  ID stage holds a real instruction
- id_rs_i  in  REG_AW  ID source register 1
- id_rt_i  in  REG_AW  ID source register 2
- id_uses_rt_i  in  1  instruction reads rt as a source (R-type, store, branch)
- id_rd_i  in  REG_AW  ID destination register (already muxed rt/rd)
- id_regwrite_i  in  1  ID instruction writes the register file
- id_memread_i  in  1  ID instruction is a load
- branch_flush_i  in  1  ID instruction is squashed (taken branch or jump)
- mem_stall_i  in  1  data memory busy; the whole pipeline freezes
- forwardA_o  out  2  operand-1 mux select: 00 ID/EX, 10 EX/MEM, 01 MEM/WB
- forwardB_o  out  2  operand-2 mux select, same encoding
- pc_write_o  out  1  PC register enable
- ifid_write_o  out  1  IF/ID register enable
- idex_bubble_o  out  1  ID/EX loads a NOP this cycle
- load_use_cnt_o  out  CNT_W  count of load-use stall cycles
- mem_stall_cnt_o  out  CNT_W  count of mem_stall_i cycles

Behaviour:
- State:
  - EX slot: {v, rs, rt, rd, regwrite, memread}.
  - MEM slot and WB slot: {v, rd, regwrite, memread}.
  - A slot counts as writing only when v=1, regwrite=1 and rd!=0.
- Reset (rst_i=1 at clock edge):
  - All slot v=0. Counters=0.
  - While rst_i is high, outputs are forced: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, forwardA_o=forwardB_o=00.
- Forwarding (combinational from slot state):
  - forwardA_o=10 if the MEM slot is writing, MEM.memread=0 and MEM.rd==EX.rs.
  - Else forwardA_o=01 if the WB slot is writing and WB.rd==EX.rs.
  - Else forwardA_o=00.
  - forwardB_o uses the same rule with EX.rt.
  - EX/MEM has priority over MEM/WB. Both are 00 when EX.v=0.
- load_use (combinational):
  - Condition: id_valid_i, EX slot writing, EX.memread=1, and either EX.rd==id_rs_i, or (id_uses_rt_i and EX.rd==id_rt_i).
  - Masked when branch_flush_i=1.
- Priority of controls per cycle:
  1. mem_stall_i=1: pc_write_o=0, ifid_write_o=0, idex_bubble_o=0. No slot changes. Forward outputs hold.
  2. load_use=1: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
  3. Otherwise: pc_write_o=1, ifid_write_o=1, idex_bubble_o=branch_flush_i.
- Slot advance at clock edge when mem_stall_i=0:
  - WB<=MEM and MEM<=EX.
  - EX<=ID fields with v=id_valid_i, except EX.v<=0 when load_use or branch_flush_i.
- Latency:
  - A load followed by a dependent instruction costs exactly 1 bubble.
  - The dependent instruction then reaches EX with the load in WB and gets select 01.
- mem_stall_i during a load-use stall: the stall takes priority and state freezes. The bubble is inserted on the first non-frozen cycle.
- Counters:
  - load_use_cnt_o increments on each edge with load_use=1 and mem_stall_i=0.
  - mem_stall_cnt_o increments on each edge with mem_stall_i=1.
  - Both saturate at all-ones and do not wrap.
- The register file writes before it reads. No ID-stage bypass is generated here.
- Writes to r0 are never forwarded and never cause a stall.

Test Plan:
- Reset: hold rst_i 2 cycles with id_valid_i=1 -> forwards 00, pc_write_o=0, idex_bubble_o=1, counters 0. First cycle after release -> pc_write_o=1.
- `add r3,r1,r2` then `sub r4,r3,r5` -> when sub is in EX, forwardA_o=10 and forwardB_o=00. One cycle later an instruction reading r3 in EX gets 01.
- r3 written in both MEM and WB slots, EX reads r3 as rt -> forwardB_o=10 (priority). Same case with rd=0 -> 00.
- `lw r2,0(r1)` then `add r4,r2,r2` -> one cycle with pc_write_o=0, ifid_write_o=0, idex_bubble_o=1. Next cycle add is in EX with forwardA_o=forwardB_o=01. load_use_cnt_o=1.
- Load-use condition together with mem_stall_i=1 for 3 cycles -> idex_bubble_o=0 and state frozen during stall, mem_stall_cnt_o=3. Then exactly one bubble follows.
- branch_flush_i=1 while ID holds a load-dependent instruction -> no stall, idex_bubble_o=1, EX slot invalid next cycle, load_use_cnt_o unchanged.

Source files
------------

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage decode and pipeline-control bundle between the core datapath and fwd_hazard_ctrl.
// The datapath side uses the master modport; the controller uses slave.
interface fwd_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              id_uses_rt_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_regwrite_i;
  logic              id_memread_i;
  logic              branch_flush_i;
  logic              mem_stall_i;

  logic [1:0]        forwardA_o;
  logic [1:0]        forwardB_o;
  logic              pc_write_o;
  logic              ifid_write_o;
  logic              idex_bubble_o;
  logic [CNT_W-1:0]  load_use_cnt_o;
  logic [CNT_W-1:0]  mem_stall_cnt_o;

  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_uses_rt_i, id_rd_i, id_regwrite_i, id_memread_i,
    output branch_flush_i, mem_stall_i,
    input  forwardA_o, forwardB_o, pc_write_o, ifid_write_o, idex_bubble_o,
    input  load_use_cnt_o, mem_stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_uses_rt_i, id_rd_i, id_regwrite_i, id_memread_i,
    input  branch_flush_i, mem_stall_i,
    output forwardA_o, forwardB_o, pc_write_o, ifid_write_o, idex_bubble_o,
    output load_use_cnt_o, mem_stall_cnt_o
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller for the 5-stage core.
// Shadows the EX/MEM/WB destination registers and drives stall, bubble and counter outputs.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fwd_hazard_ctrl_if.slave   io_bus
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic              r_ex_v;
  logic [REG_AW-1:0] r_ex_rs;
  logic [REG_AW-1:0] r_ex_rt;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_rw;
  logic              r_ex_mr;
  logic              r_mem_v;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_mem_rw;
  logic              r_mem_mr;
  logic              r_wb_v;
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_rw;
  logic [CNT_W-1:0]  r_lu_cnt;
  logic [CNT_W-1:0]  r_ms_cnt;

  logic              w_ex_wr;
  logic              w_mem_wr;
  logic              w_wb_wr;
  logic              w_load_use;
  logic              w_stall;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;
  logic              w_pc_write;
  logic              w_ifid_write;
  logic              w_bubble;

  // r0 is hardwired, so a slot targeting it never produces a value worth forwarding.
  assign w_ex_wr  = r_ex_v  && r_ex_rw  && (r_ex_rd  != '0);
  assign w_mem_wr = r_mem_v && r_mem_rw && (r_mem_rd != '0);
  assign w_wb_wr  = r_wb_v  && r_wb_rw  && (r_wb_rd  != '0);
  assign w_stall  = io_bus.mem_stall_i;

  assign w_load_use = io_bus.id_valid_i && w_ex_wr && r_ex_mr && !io_bus.branch_flush_i &&
                      ((r_ex_rd == io_bus.id_rs_i) ||
                       (io_bus.id_uses_rt_i && (r_ex_rd == io_bus.id_rt_i)));

  // A load in MEM has no data yet, so only non-load MEM results are bypassed.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (r_ex_v) begin
      if (w_mem_wr && !r_mem_mr && (r_mem_rd == r_ex_rs)) begin
        w_fwd_a = 2'b10;
      end else if (w_wb_wr && (r_wb_rd == r_ex_rs)) begin
        w_fwd_a = 2'b01;
      end
      if (w_mem_wr && !r_mem_mr && (r_mem_rd == r_ex_rt)) begin
        w_fwd_b = 2'b10;
      end else if (w_wb_wr && (r_wb_rd == r_ex_rt)) begin
        w_fwd_b = 2'b01;
      end
    end
  end

  always_comb begin
    w_pc_write   = 1'b1;
    w_ifid_write = 1'b1;
    w_bubble     = io_bus.branch_flush_i;
    if (rst_i) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_bubble     = 1'b1;
    end else if (w_stall) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_bubble     = 1'b0;
    end else if (w_load_use) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_bubble     = 1'b1;
    end
  end

  assign io_bus.forwardA_o      = rst_i ? 2'b00 : w_fwd_a;
  assign io_bus.forwardB_o      = rst_i ? 2'b00 : w_fwd_b;
  assign io_bus.pc_write_o      = w_pc_write;
  assign io_bus.ifid_write_o    = w_ifid_write;
  assign io_bus.idex_bubble_o   = w_bubble;
  assign io_bus.load_use_cnt_o  = r_lu_cnt;
  assign io_bus.mem_stall_cnt_o = r_ms_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ex_v   <= 1'b0;
      r_ex_rs  <= '0;
      r_ex_rt  <= '0;
      r_ex_rd  <= '0;
      r_ex_rw  <= 1'b0;
      r_ex_mr  <= 1'b0;
      r_mem_v  <= 1'b0;
      r_mem_rd <= '0;
      r_mem_rw <= 1'b0;
      r_mem_mr <= 1'b0;
      r_wb_v   <= 1'b0;
      r_wb_rd  <= '0;
      r_wb_rw  <= 1'b0;
    end else if (!w_stall) begin
      r_wb_v   <= r_mem_v;
      r_wb_rd  <= r_mem_rd;
      r_wb_rw  <= r_mem_rw;
      r_mem_v  <= r_ex_v;
      r_mem_rd <= r_ex_rd;
      r_mem_rw <= r_ex_rw;
      r_mem_mr <= r_ex_mr;
      r_ex_v   <= io_bus.id_valid_i && !w_load_use && !io_bus.branch_flush_i;
      r_ex_rs  <= io_bus.id_rs_i;
      r_ex_rt  <= io_bus.id_rt_i;
      r_ex_rd  <= io_bus.id_rd_i;
      r_ex_rw  <= io_bus.id_regwrite_i;
      r_ex_mr  <= io_bus.id_memread_i;
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lu_cnt <= '0;
      r_ms_cnt <= '0;
    end else begin
      if (!w_stall && w_load_use && (r_lu_cnt != '1)) begin
        r_lu_cnt <= r_lu_cnt + CntOne;
      end
      if (w_stall && (r_ms_cnt != '1)) begin
        r_ms_cnt <= r_ms_cnt + CntOne;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed table-driven bench for fwd_hazard_ctrl, plus a narrow-counter instance for saturation.
module tb_fwd_hazard_ctrl;

  localparam logic       L0 = 1'b0;
  localparam logic       L1 = 1'b1;
  localparam logic [1:0] F0 = 2'b00;
  localparam logic [1:0] FE = 2'b10;
  localparam logic [1:0] FW = 2'b01;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       fl;
    logic       st;
    logic [1:0] ea;
    logic [1:0] eb;
    logic       epc;
    logic       eif;
    logic       ebub;
    int unsigned elu;
    int unsigned ems;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus ();
  fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(2))  bus2 ();

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) u_dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .io_bus (bus)
  );

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(2)) u_dut_sat (
    .clk_i  (clk),
    .rst_i  (rst),
    .io_bus (bus2)
  );

  assign bus2.id_valid_i     = bus.id_valid_i;
  assign bus2.id_rs_i        = bus.id_rs_i;
  assign bus2.id_rt_i        = bus.id_rt_i;
  assign bus2.id_uses_rt_i   = bus.id_uses_rt_i;
  assign bus2.id_rd_i        = bus.id_rd_i;
  assign bus2.id_regwrite_i  = bus.id_regwrite_i;
  assign bus2.id_memread_i   = bus.id_memread_i;
  assign bus2.branch_flush_i = bus.branch_flush_i;
  assign bus2.mem_stall_i    = bus.mem_stall_i;

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst                = v.rst;
    bus.id_valid_i     = v.vld;
    bus.id_rs_i        = v.rs;
    bus.id_rt_i        = v.rt;
    bus.id_uses_rt_i   = v.urt;
    bus.id_rd_i        = v.rd;
    bus.id_regwrite_i  = v.rw;
    bus.id_memread_i   = v.mr;
    bus.branch_flush_i = v.fl;
    bus.mem_stall_i    = v.st;
  endtask

  initial begin
    // rst vld rs rt urt rd rw mr fl st | fwdA fwdB pc ifid bubble lu_cnt ms_cnt
    // Reset held with a valid instruction in ID.
    vecs.push_back('{L1, L1, 5'd1, 5'd2, L1, 5'd3, L1, L0, L0, L0, F0, F0, L0, L0, L1, 0, 0});
    vecs.push_back('{L1, L1, 5'd1, 5'd2, L1, 5'd3, L1, L0, L0, L0, F0, F0, L0, L0, L1, 0, 0});
    // add r3,r1,r2 ; sub r4,r3,r5 ; or r6,r7,r3
    vecs.push_back('{L0, L1, 5'd1, 5'd2, L1, 5'd3, L1, L0, L0, L0, F0, F0, L1, L1, L0, 0, 0});
    vecs.push_back('{L0, L1, 5'd3, 5'd5, L1, 5'd4, L1, L0, L0, L0, F0, F0, L1, L1, L0, 0, 0});
    vecs.push_back('{L0, L1, 5'd7, 5'd3, L1, 5'd6, L1, L0, L0, L0, FE, F0, L1, L1, L0, 0, 0});
    vecs.push_back('{L0, L0, 5'd0, 5'd0, L0, 5'd0, L0, L0, L0, L0, F0, FW, L1, L1, L0, 0, 0});
    // r3 written twice, then and r8,r9,r3: MEM/WB both match, EX/MEM wins.
    vecs.push_back('{L0, L1, 5'd1, 5'd1, L1, 5'd3, L1, L0, L0, L0, F0, F0, L1, L1, L0, 0, 0});
    vecs.push_back('{L0, L1, 5'd2, 5'd2, L1, 5'd3, L1, L0, L0, L0, F0, F0, L1, L1, L0, 0, 0});
    vecs.push_back('{L0, L1, 5'd9, 5'd3, L1, 5'd8, L1, L0, L0, L0, F0, F0, L1, L1, L0, 0, 0});
    vecs.push_back('{L0, L0, 5'd0, 5'd0, L0, 5'd0, L0, L0, L0, L0, F0, FE, L1, L1, L0, 0, 0});
    // Same shape targeting r0: never forwarded.
    vecs.push_back('{L0, L1, 5'd1, 5'd1, L1, 5'd0, L1, L0, L0, L0, F0, F0, L1, L1, L0, 0, 0});
    vecs.push_back('{L0, L1, 5'd2, 5'd2, L1, 5'd0, L1, L0, L0, L0, F0, F0, L1, L1, L0, 0, 0});
    vecs.push_back('{L0, L1, 5'd9, 5'd0, L1, 5'd8, L1, L0, L0, L0, F0, F0, L1, L1, L0, 0, 0});
    vecs.push_back('{L0, L0, 5'd0, 5'd0, L0, 5'd0, L0, L0, L0, L0, F0, F0, L1, L1, L0, 0, 0});
    // lw r2,0(r1) ; add r4,r2,r2 -> one bubble, then 01 on both operands.
    vecs.push_back('{L0, L1, 5'd1, 5'd2, L0, 5'd2, L1, L1, L0, L0, F0, F0, L1, L1, L0, 0, 0});
    vecs.push_back('{L0, L1, 5'd2, 5'd2, L1, 5'd4, L1, L0, L0, L0, F0, F0, L0, L0, L1, 0, 0});
    vecs.push_back('{L0, L1, 5'd2, 5'd2, L1, 5'd4, L1, L0, L0, L0, F0, F0, L1, L1, L0, 1, 0});
    vecs.push_back('{L0, L0, 5'd0, 5'd0, L0, 5'd0, L0, L0, L0, L0, FW, FW, L1, L1, L0, 1, 0});
    // lw r5 ; sub r6,r7,r5 with 3 frozen cycles before the bubble.
    vecs.push_back('{L0, L1, 5'd1, 5'd5, L0, 5'd5, L1, L1, L0, L0, F0, F0, L1, L1, L0, 1, 0});
    vecs.push_back('{L0, L1, 5'd7, 5'd5, L1, 5'd6, L1, L0, L0, L1, F0, F0, L0, L0, L0, 1, 0});
    vecs.push_back('{L0, L1, 5'd7, 5'd5, L1, 5'd6, L1, L0, L0, L1, F0, F0, L0, L0, L0, 1, 1});
    vecs.push_back('{L0, L1, 5'd7, 5'd5, L1, 5'd6, L1, L0, L0, L1, F0, F0, L0, L0, L0, 1, 2});
    vecs.push_back('{L0, L1, 5'd7, 5'd5, L1, 5'd6, L1, L0, L0, L0, F0, F0, L0, L0, L1, 1, 3});
    vecs.push_back('{L0, L1, 5'd7, 5'd5, L1, 5'd6, L1, L0, L0, L0, F0, F0, L1, L1, L0, 2, 3});
    // Forward select holds across a freeze.
    vecs.push_back('{L0, L0, 5'd0, 5'd0, L0, 5'd0, L0, L0, L0, L1, F0, FW, L0, L0, L0, 2, 3});
    vecs.push_back('{L0, L0, 5'd0, 5'd0, L0, 5'd0, L0, L0, L0, L0, F0, FW, L1, L1, L0, 2, 4});
    // lw r2 ; squashed lw r9,0(r2) ; add r10,r9,r9 must not stall on the squashed load.
    vecs.push_back('{L0, L1, 5'd1, 5'd2, L0, 5'd2, L1, L1, L0, L0, F0, F0, L1, L1, L0, 2, 4});
    vecs.push_back('{L0, L1, 5'd2, 5'd9, L0, 5'd9, L1, L1, L1, L0, F0, F0, L1, L1, L1, 2, 4});
    vecs.push_back('{L0, L1, 5'd9, 5'd9, L1, 5'd10, L1, L0, L0, L0, F0, F0, L1, L1, L0, 2, 4});
    vecs.push_back('{L0, L0, 5'd0, 5'd0, L0, 5'd0, L0, L0, L0, L0, F0, F0, L1, L1, L0, 2, 4});

    drive(vecs[0]);
    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk("forwardA",      i, 32'(bus.forwardA_o),    32'(vecs[i].ea));
      chk("forwardB",      i, 32'(bus.forwardB_o),    32'(vecs[i].eb));
      chk("pc_write",      i, 32'(bus.pc_write_o),    32'(vecs[i].epc));
      chk("ifid_write",    i, 32'(bus.ifid_write_o),  32'(vecs[i].eif));
      chk("idex_bubble",   i, 32'(bus.idex_bubble_o), 32'(vecs[i].ebub));
      chk("load_use_cnt",  i, bus.load_use_cnt_o,     vecs[i].elu);
      chk("mem_stall_cnt", i, bus.mem_stall_cnt_o,    vecs[i].ems);
      @(posedge clk);
      #1;
    end

    // 2-bit counters: 2 load-use edges fit, 4 stall edges saturate at 3.
    chk("sat_load_use_cnt",  99, 32'(bus2.load_use_cnt_o),  32'd2);
    chk("sat_mem_stall_cnt", 99, 32'(bus2.mem_stall_cnt_o), 32'd3);

    // Reset re-asserted mid-stream clears the counters.
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_load_use_cnt",  100, bus.load_use_cnt_o,  32'd0);
    chk("rst_mem_stall_cnt", 100, bus.mem_stall_cnt_o, 32'd0);
    chk("rst_pc_write",      100, 32'(bus.pc_write_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
